// File: rtl/vga_draw_scheduler.sv
// Draw scheduler for a 30x29 playfield of 4x4 cells plus a one-row player strip.
// Serialises field and player repaints into a single VGA-adapter pixel stream.
module vga_draw_scheduler (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_field_req,
  input  logic        i_player_req,
  input  logic [29:0] i_player_pos,
  output logic        o_cell_rd,
  output logic [4:0]  o_cell_col,
  output logic [4:0]  o_cell_row,
  input  logic [1:0]  i_cell_data,
  output logic [7:0]  o_x,
  output logic [6:0]  o_y,
  output logic [2:0]  o_colour,
  output logic        o_plot,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int unsigned COLS   = 30;
  localparam int unsigned POS_W  = 5;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam logic [POS_W-1:0] LAST_COL = POS_W'(29);
  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(28);
  localparam logic [Y_W-1:0]   PLAYER_Y = Y_W'(116);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_FETCH,
    S_F_PAINT,
    S_P_PAINT,
    S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [POS_W-1:0]   r_col, w_col, r_row, w_row;
  logic [1:0]         r_dx, w_dx, r_dy, w_dy;
  logic [1:0]         r_cell, w_cell, w_cell_v;
  logic [COLS-1:0]    r_snap, w_snap;
  logic               r_fpend, w_fpend, r_ppend, w_ppend;
  logic               w_fstart, w_pstart, w_last_px;
  logic [X_W-1:0]     r_x, w_x;
  logic [Y_W-1:0]     r_y, w_y;
  logic [2:0]         r_colour, w_colour;
  logic               r_plot, w_plot, r_cell_rd, w_cell_rd;
  logic               r_busy, w_busy, r_frame_done, w_frame_done;

  function automatic logic [2:0] field_colour(input logic [1:0] d);
    case (d)
      2'b00:   field_colour = 3'd3;
      2'b10:   field_colour = 3'd2;
      default: field_colour = 3'd4;
    endcase
  endfunction

  // Next-state, counter and output decode; everything holds while disabled.
  always_comb begin
    w_state      = r_state;
    w_col        = r_col;
    w_row        = r_row;
    w_dx         = r_dx;
    w_dy         = r_dy;
    w_cell       = r_cell;
    w_snap       = r_snap;
    w_x          = r_x;
    w_y          = r_y;
    w_colour     = r_colour;
    w_plot       = 1'b0;
    w_cell_rd    = 1'b0;
    w_frame_done = 1'b0;
    w_fstart     = 1'b0;
    w_pstart     = 1'b0;
    w_last_px    = (r_dx == 2'd3) && (r_dy == 2'd3);
    // First paint cycle uses the store output directly; later cycles the captured copy.
    w_cell_v     = (r_dx == 2'd0 && r_dy == 2'd0) ? i_cell_data : r_cell;

    if (i_enable) begin
      case (r_state)
        S_IDLE: begin
          if (r_ppend) begin
            w_state  = S_P_PAINT;
            w_pstart = 1'b1;
            w_snap   = i_player_pos;
            w_col    = '0;
            w_row    = '0;
            w_dx     = '0;
            w_dy     = '0;
          end else if (r_fpend) begin
            w_state   = S_F_FETCH;
            w_fstart  = 1'b1;
            w_cell_rd = 1'b1;
            w_col     = '0;
            w_row     = '0;
            w_dx      = '0;
            w_dy      = '0;
          end
        end
        S_F_FETCH: w_state = S_F_PAINT;
        S_F_PAINT: begin
          w_cell   = w_cell_v;
          w_plot   = 1'b1;
          w_x      = X_W'({r_col, r_dx});
          w_y      = {r_row, r_dy};
          w_colour = field_colour(w_cell_v);
          w_dx     = r_dx + 2'd1;
          if (r_dx == 2'd3) w_dy = r_dy + 2'd1;
          if (w_last_px) begin
            if (r_col == LAST_COL) begin
              w_col = '0;
              if (r_row == LAST_ROW) begin
                w_row   = '0;
                w_state = S_DONE;
              end else begin
                w_row     = r_row + POS_W'(1);
                w_state   = S_F_FETCH;
                w_cell_rd = 1'b1;
              end
            end else begin
              w_col     = r_col + POS_W'(1);
              w_state   = S_F_FETCH;
              w_cell_rd = 1'b1;
            end
          end
        end
        S_P_PAINT: begin
          w_plot   = 1'b1;
          w_x      = X_W'({r_col, r_dx});
          w_y      = PLAYER_Y + Y_W'(r_dy);
          w_colour = r_snap[r_col] ? 3'd6 : 3'd5;
          w_dx     = r_dx + 2'd1;
          if (r_dx == 2'd3) w_dy = r_dy + 2'd1;
          if (w_last_px) begin
            if (r_col == LAST_COL) begin
              w_col   = '0;
              w_state = S_DONE;
            end else begin
              w_col = r_col + POS_W'(1);
            end
          end
        end
        S_DONE: begin
          w_frame_done = 1'b1;
          w_state      = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end

    // Requests latch regardless of enable; a request on the start cycle re-arms the flag.
    w_fpend = (r_fpend & ~w_fstart) | i_field_req;
    w_ppend = (r_ppend & ~w_pstart) | i_player_req;
    w_busy  = (w_state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_cell       <= '0;
      r_snap       <= '0;
      r_fpend      <= 1'b0;
      r_ppend      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_cell_rd    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_col        <= w_col;
      r_row        <= w_row;
      r_dx         <= w_dx;
      r_dy         <= w_dy;
      r_cell       <= w_cell;
      r_snap       <= w_snap;
      r_fpend      <= w_fpend;
      r_ppend      <= w_ppend;
      r_x          <= w_x;
      r_y          <= w_y;
      r_colour     <= w_colour;
      r_plot       <= w_plot;
      r_cell_rd    <= w_cell_rd;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
    end
  end

  assign o_cell_rd    = r_cell_rd;
  assign o_cell_col   = r_col;
  assign o_cell_row   = r_row;
  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_colour     = r_colour;
  assign o_plot       = r_plot;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: expected pixels are queued per requested
// pass and popped as the scheduler plots; a small store model answers cell reads.
module tb_vga_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, field_req, player_req;
  logic [29:0] player_pos;
  logic        cell_rd;
  logic [4:0]  cell_col, cell_row;
  logic [1:0]  cell_data = 2'b00;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, frame_done;

  always #5 clk = ~clk;

  vga_draw_scheduler dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_field_req  (field_req),
    .i_player_req (player_req),
    .i_player_pos (player_pos),
    .o_cell_rd    (cell_rd),
    .o_cell_col   (cell_col),
    .o_cell_row   (cell_row),
    .i_cell_data  (cell_data),
    .o_x          (x),
    .o_y          (y),
    .o_colour     (colour),
    .o_plot       (plot),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [17:0] sb[$];
  logic [1:0]  mem [30][29];
  int   cyc = 0, n_plot = 0, n_fd = 0, n_rd = 0, rise_cyc = 0, fd_cyc = 0;
  logic prev_busy = 1'b0;

  // Playfield store: data one cycle after a read, held while not read.
  always @(posedge clk) begin
    if (cell_rd) cell_data <= mem[cell_col][cell_row];
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [17:0] e;
    cyc++;
    if (plot) begin
      n_plot++;
      if (sb.size() == 0) check("extra_plot", 32'(plot), 32'd0);
      else begin
        e = sb.pop_front();
        check("pixel", 32'({x, y, colour}), 32'(e));
      end
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
    if (cell_rd) n_rd++;
    if (busy && !prev_busy) rise_cyc = cyc;
    prev_busy = busy;
  end

  function automatic logic [2:0] fcol(input logic [1:0] d);
    case (d)
      2'b00:   return 3'd3;
      2'b10:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_player(input logic [29:0] pos);
    for (int c = 0; c < 30; c++)
      for (int dy = 0; dy < 4; dy++)
        for (int dx = 0; dx < 4; dx++)
          sb.push_back({8'(4*c+dx), 7'(116+dy), (pos[c] ? 3'd6 : 3'd5)});
  endtask

  task automatic push_field();
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 30; c++)
        for (int dy = 0; dy < 4; dy++)
          for (int dx = 0; dx < 4; dx++)
            sb.push_back({8'(4*c+dx), 7'(4*r+dy), fcol(mem[c][r])});
  endtask

  task automatic fill(input bit rnd);
    for (int c = 0; c < 30; c++)
      for (int r = 0; r < 29; r++)
        mem[c][r] = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
  endtask

  task automatic pulse(input bit f, input bit p);
    field_req  = f;
    player_req = p;
    tick();
    field_req  = 1'b0;
    player_req = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int start;
    int k;
    start = n_fd;
    k = 0;
    while (n_fd == start && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(n_fd > start), 32'd1);
  endtask

  initial begin
    int bp, brd, bfd, k, np;
    logic [17:0] hold;
    reset = 1'b1; enable = 1'b1; field_req = 1'b0; player_req = 1'b0; player_pos = '0;
    fill(1'b0);

    // Reset values, and a request coincident with reset is dropped
    tick(3);
    check("reset_outs", 32'({x, y, colour, plot, cell_rd, busy, frame_done}), 32'd0);
    field_req = 1'b1;
    tick();
    field_req = 1'b0;
    reset = 1'b0;
    tick(20);
    check("dropped_busy", 32'(busy), 32'd0);
    check("dropped_plots", 32'(n_plot), 32'd0);

    // Player pass, snapshot taken at pass start
    player_pos = 30'h1;
    push_player(30'h1);
    bp = n_plot;
    pulse(1'b0, 1'b1);
    tick(3);
    player_pos = 30'h2AAAAAAA;
    wait_fd("p_fd_wait", 700);
    check("p_plots", 32'(n_plot - bp), 32'd480);
    check("p_fd_time", 32'(fd_cyc - rise_cyc), 32'd481);
    tick();
    check("p_busy_end", 32'(busy), 32'd0);
    check("p_sb_empty", 32'(sb.size()), 32'd0);

    // Field pass with a pause right after a fetch and a 100-cycle pause mid-paint
    fill(1'b0);
    mem[2][1] = 2'b10; mem[5][0] = 2'b01; mem[29][28] = 2'b11;
    push_field();
    bp = n_plot; brd = n_rd;
    pulse(1'b1, 1'b0);
    k = 0;
    while (!(cell_rd && cell_col == 5'd2 && cell_row == 5'd1) && k < 1000) begin
      tick();
      k++;
    end
    check("rd_2_1_seen", 32'(k < 1000), 32'd1);
    tick();
    enable = 1'b0;
    tick(5);
    enable = 1'b1;
    tick(3000);
    k = 0;
    while (!plot && k < 20) begin
      tick();
      k++;
    end
    enable = 1'b0;
    tick();
    np = n_plot;
    hold = {x, y, colour};
    tick(99);
    check("gap_no_plots", 32'(n_plot - np), 32'd0);
    check("gap_hold", 32'({x, y, colour}), 32'(hold));
    check("gap_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    wait_fd("f_fd_wait", 16000);
    check("f_plots", 32'(n_plot - bp), 32'd13920);
    check("f_reads", 32'(n_rd - brd), 32'd870);
    check("f_fd_time", 32'(fd_cyc - rise_cyc), 32'd14896);
    tick();
    check("f_busy_end", 32'(busy), 32'd0);
    check("f_sb_empty", 32'(sb.size()), 32'd0);

    // Simultaneous requests: player pass first, then field
    player_pos = 30'h20000001;
    push_player(30'h20000001);
    fill(1'b1);
    push_field();
    bp = n_plot; bfd = n_fd;
    pulse(1'b1, 1'b1);
    tick(3);
    player_pos = '0;
    wait_fd("both_fd1", 700);
    wait_fd("both_fd2", 16000);
    tick();
    check("both_fd_count", 32'(n_fd - bfd), 32'd2);
    check("both_plots", 32'(n_plot - bp), 32'd14400);
    check("both_sb_empty", 32'(sb.size()), 32'd0);
    check("both_busy_end", 32'(busy), 32'd0);

    // Two player requests during a field pass coalesce into one player pass
    fill(1'b0);
    mem[7][13] = 2'b10;
    push_field();
    player_pos = 30'h0F0F0F0F;
    bp = n_plot; bfd = n_fd;
    pulse(1'b1, 1'b0);
    tick(1000);
    pulse(1'b0, 1'b1);
    push_player(30'h0F0F0F0F);
    tick(2000);
    pulse(1'b0, 1'b1);
    wait_fd("coal_fd1", 16000);
    wait_fd("coal_fd2", 700);
    tick(600);
    check("coal_fd_count", 32'(n_fd - bfd), 32'd2);
    check("coal_plots", 32'(n_plot - bp), 32'd14400);
    check("coal_sb_empty", 32'(sb.size()), 32'd0);
    check("coal_busy_end", 32'(busy), 32'd0);

    // Reset mid-pass aborts with no frame_done; a new request restarts at (0,0)
    fill(1'b1);
    push_field();
    pulse(1'b1, 1'b0);
    tick(5000);
    bfd = n_fd;
    reset = 1'b1;
    tick();
    check("abort_plot_busy", 32'({plot, busy}), 32'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    tick(50);
    check("abort_no_fd", 32'(n_fd - bfd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    push_field();
    pulse(1'b1, 1'b0);
    k = 0;
    while (!cell_rd && k < 10) begin
      tick();
      k++;
    end
    check("restart_rd_seen", 32'(k < 10), 32'd1);
    check("restart_addr", 32'({cell_col, cell_row}), 32'd0);
    bp = n_plot;
    tick(17 * 4);
    check("restart_plotting", 32'(n_plot > bp), 32'd1);
    reset = 1'b1;
    tick();
    sb.delete();
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_draw_scheduler.md
VGA_DRAW_SCHEDULER -- requirements
Module: vga_draw_scheduler

Interface
REQ-001 clk  in  1  system clock (CLOCK_50 domain); all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 enable  in  1  1 = advance; 0 = freeze all state, plot forced 0.
REQ-004 field_req  in  1  one-cycle pulse requesting full playfield repaint.
REQ-005 player_req  in  1  one-cycle pulse requesting player-row repaint.
REQ-006 player_pos  in  30  one-hot player bitmap; bit i = column i.
REQ-007 cell_rd  out  1  one-cycle read strobe to playfield store.
REQ-008 cell_col  out  5  column address 0..29, valid with cell_rd.
REQ-009 cell_row  out  5  row address 0..28, valid with cell_rd.
REQ-010 cell_data  in  2  cell contents; valid exactly one cycle after cell_rd.
REQ-011 x  out  8  pixel x to VGA adapter.
REQ-012 y  out  7  pixel y to VGA adapter.
REQ-013 colour  out  3  pixel colour to VGA adapter.
REQ-014 plot  out  1  write enable; x/y/colour valid whenever plot=1.
REQ-015 busy  out  1  1 whenever state is not IDLE.
REQ-016 frame_done  out  1  one-cycle pulse after last pixel of any pass.

Function
REQ-017 States: IDLE, F_FETCH, F_PAINT, P_PAINT, DONE.
REQ-018 field_req/player_req each set a pending flag; repeat requests while pending coalesce into one.
REQ-019 IDLE: player pending -> P_PAINT (priority); else field pending -> F_FETCH; else stay IDLE.
REQ-020 Pending flag cleared on the cycle its pass starts; a request arriving that same cycle re-sets it.
REQ-021 F_FETCH: cell_rd=1 for one cycle with current (col,row), then F_PAINT.
REQ-022 F_PAINT: capture cell_data on first cycle; emit 16 plots, dx 0..3 fastest, then dy 0..3.
REQ-023 Field pixel: x = 4*col+dx, y = 4*row+dy.
REQ-024 Field colour: 00 -> 3, 10 -> 2, 01 or 11 -> 4.
REQ-025 Field cell order: col 0..29 fastest, row 0..28; 17 cycles per cell; 14790 cycles per pass.
REQ-026 After cell (29,28): -> DONE.
REQ-027 P_PAINT: snapshot player_pos on entry; later changes do not affect the current pass.
REQ-028 Player pixel: x = 4*i+dx, y = 116+dy, i = 0..29; colour 6 if snapshot bit i = 1, else 5.
REQ-029 Player pass: 30 cells x 16 plots, no fetch; 480 cycles.
REQ-030 DONE: frame_done=1 for one cycle, plot=0, then IDLE.
REQ-031 Passes never interleave; a request arriving during a pass waits for DONE.
REQ-032 x, y, colour and plot are registered; plot=0 in IDLE, F_FETCH and DONE.
REQ-033 enable=0: counters, state, snapshot and pending flags hold; plot=0, cell_rd=0; requests still latch.
REQ-034 enable deasserted the cycle after cell_rd: cell_data is captured on resumption; the store holds data while not read.
REQ-035 Counter widths: dx,dy 2 bits; col wraps at 29, row ends at 28; no intermediate overflow.

Reset
REQ-036 reset=1: state IDLE, pending flags cleared, counters 0, snapshot 0.
REQ-037 Outputs under reset: x=0, y=0, colour=0, plot=0, cell_rd=0, busy=0, frame_done=0.
REQ-038 Reset mid-pass aborts immediately with no frame_done; requests coincident with reset are dropped.

Verification
REQ-039 reset, then player_req with player_pos=30'h1 -> 480 plots; x=0..3,y=116..119 colour 6; all other cells colour 5; frame_done at cycle 481.
REQ-040 field_req, store all 00 except (col 2,row 1)=10 -> 870 cell_rd strobes; pixels x=8..11,y=4..7 colour 2; rest colour 3; busy low after frame_done.
REQ-041 field_req and player_req on the same cycle -> player pass completes first, then field pass; two frame_done pulses.
REQ-042 player_req twice during a field pass -> exactly one player pass after the field DONE.
REQ-043 enable=0 for 100 cycles mid-F_PAINT -> no plots, outputs hold; resumes at the same dx/dy; total plot count unchanged.
REQ-044 reset at cycle 5000 of a field pass -> next cycle plot=0, busy=0; no frame_done; a new field_req restarts at (0,0).
